// File: rtl/mod_quad_iter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mod_quad_iter_ctrl (with mod_quad_reg, mod_quadrupler)
//  Brief    : Iterates oData = iData * 4^iCnt mod iMod, one quadrupling per clk
//  Revision : 1.0 - initial release
// ============================================================================

module mod_quad_reg #(
  parameter int WIDTH = 32
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iClr,
  input  logic             iEn,
  input  logic [WIDTH-1:0] iD,
  output logic [WIDTH-1:0] oQ
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      data_q <= '0;
    end else if (iClr) begin
      data_q <= '0;
    end else if (iEn) begin
      data_q <= iD;
    end
  end

  assign oQ = data_q;

endmodule

module mod_quadrupler #(
  parameter int BITWIDTH = 32
) (
  input  logic [BITWIDTH-1:0] iA,
  input  logic [BITWIDTH-1:0] iMod,
  output logic [BITWIDTH-1:0] oQ
);

  // Two modular doublings; for a < M each needs at most one subtraction.
  logic [BITWIDTH:0]   dbl1_w, sub1_w, dbl2_w, sub2_w, mod_ext_w;
  logic [BITWIDTH-1:0] half_w;

  assign mod_ext_w = {1'b0, iMod};
  assign dbl1_w    = {iA, 1'b0};
  assign sub1_w    = dbl1_w - mod_ext_w;
  assign half_w    = (dbl1_w >= mod_ext_w) ? sub1_w[BITWIDTH-1:0] : dbl1_w[BITWIDTH-1:0];
  assign dbl2_w    = {half_w, 1'b0};
  assign sub2_w    = dbl2_w - mod_ext_w;
  assign oQ        = (dbl2_w >= mod_ext_w) ? sub2_w[BITWIDTH-1:0] : dbl2_w[BITWIDTH-1:0];

endmodule

module mod_quad_iter_ctrl #(
  parameter int BITWIDTH = 32,
  parameter int CNTWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iClr,
  input  logic                iValid,
  output logic                oReady,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iMod,
  input  logic [CNTWIDTH-1:0] iCnt,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData,
  output logic                oBusy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNTWIDTH-1:0] count_q;
  logic [BITWIDTH-1:0] mod_q;
  logic [BITWIDTH-1:0] acc_q;
  logic [BITWIDTH-1:0] acc_d;
  logic [BITWIDTH-1:0] quad_w;
  logic                load_w;
  logic                iter_w;

  assign load_w = (state_q == S_IDLE) && iValid;
  assign iter_w = (state_q == S_RUN);

  mod_quadrupler #(
    .BITWIDTH (BITWIDTH)
  ) u_quad (
    .iA   (acc_q),
    .iMod (mod_q),
    .oQ   (quad_w)
  );

  assign acc_d = load_w ? iData : quad_w;

  mod_quad_reg #(
    .WIDTH (BITWIDTH)
  ) u_acc (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iClr  (iClr),
    .iEn   (load_w | iter_w),
    .iD    (acc_d),
    .oQ    (acc_q)
  );

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q <= S_IDLE;
      count_q <= '0;
      mod_q   <= '0;
    end else if (iClr) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iValid) begin
            mod_q   <= iMod;
            count_q <= iCnt;
            state_q <= (iCnt == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          // Leaving at count==1 keeps the counter from ever wrapping below zero.
          count_q <= count_q - CNTWIDTH'(1);
          if (count_q == CNTWIDTH'(1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (iReady) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign oReady = (state_q == S_IDLE);
  assign oBusy  = (state_q == S_RUN);
  assign oValid = (state_q == S_DONE);
  assign oData  = acc_q;

endmodule

`default_nettype wire
